// File: rtl/geofence_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : geofence_sort_ctrl
// Purpose  : Front-end sequencer for the geofence engine. Buffers NPTS
//            antenna samples, orders samples 1..NPTS-1 by angle about
//            sample 0 with a single cross-product comparator (one bubble
//            sort comparison per cycle), then streams the ordered vertices
//            downstream under valid/ready backpressure.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready, X, Y, R      - sample input handshake
//            out_valid/out_ready, out_x, out_y, out_r, out_idx, out_last
//                                            - ordered vertex output
//            busy                            - high while sorting/emitting
// Revision : 1.0 - initial release
// ============================================================================
module geofence_sort_ctrl #(
    parameter int COORD_W = 10,
    parameter int R_W     = 11,
    parameter int NPTS    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    input  logic [R_W-1:0]     R,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [R_W-1:0]     out_r,
    output logic [2:0]         out_idx,
    output logic               out_last,
    output logic               busy
);

    localparam int PROD_W  = 2 * COORD_W + 2;
    localparam int CROSS_W = PROD_W + 1;
    localparam int EXT_W   = PROD_W - COORD_W - 1;

    localparam logic [2:0] LAST_IDX  = 3'(NPTS - 1);
    localparam logic [2:0] LAST_J    = 3'(NPTS - 2);
    localparam logic [2:0] LAST_PASS = 3'(NPTS - 3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SORT = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [2:0] count_q, count_d;
    logic [2:0] pass_q,  pass_d;
    logic [2:0] j_q,     j_d;
    logic [2:0] k_q,     k_d;

    logic [COORD_W-1:0] x_q [NPTS];
    logic [COORD_W-1:0] x_d [NPTS];
    logic [COORD_W-1:0] y_q [NPTS];
    logic [COORD_W-1:0] y_d [NPTS];
    logic [R_W-1:0]     r_q [NPTS];
    logic [R_W-1:0]     r_d [NPTS];
    logic [2:0]         perm_q [NPTS];
    logic [2:0]         perm_d [NPTS];

    // ------------------------------------------------------------------
    // Cross-product comparator on the pair (perm[j], perm[j+1]).
    // Differences need one extra bit for sign; products are sign-extended
    // to full width before multiplying so nothing is truncated.
    // ------------------------------------------------------------------
    logic [2:0]                w_j1;
    logic [2:0]                w_ia;
    logic [2:0]                w_ib;
    logic signed [COORD_W:0]   w_ax, w_ay, w_bx, w_by;
    logic signed [PROD_W-1:0]  w_ax_e, w_ay_e, w_bx_e, w_by_e;
    logic signed [PROD_W-1:0]  w_prod_ab, w_prod_ba;
    logic signed [CROSS_W-1:0] w_cross;
    logic                      w_swap;

    assign w_j1 = j_q + 3'd1;
    assign w_ia = perm_q[j_q];
    assign w_ib = perm_q[w_j1];

    assign w_ax = $signed({1'b0, x_q[w_ia]}) - $signed({1'b0, x_q[0]});
    assign w_ay = $signed({1'b0, y_q[w_ia]}) - $signed({1'b0, y_q[0]});
    assign w_bx = $signed({1'b0, x_q[w_ib]}) - $signed({1'b0, x_q[0]});
    assign w_by = $signed({1'b0, y_q[w_ib]}) - $signed({1'b0, y_q[0]});

    assign w_ax_e = {{EXT_W{w_ax[COORD_W]}}, w_ax};
    assign w_ay_e = {{EXT_W{w_ay[COORD_W]}}, w_ay};
    assign w_bx_e = {{EXT_W{w_bx[COORD_W]}}, w_bx};
    assign w_by_e = {{EXT_W{w_by[COORD_W]}}, w_by};

    assign w_prod_ab = w_ax_e * w_by_e;
    assign w_prod_ba = w_ay_e * w_bx_e;
    assign w_cross   = {w_prod_ab[PROD_W-1], w_prod_ab} - {w_prod_ba[PROD_W-1], w_prod_ba};

    // Strictly negative cross means b precedes a; ties keep arrival order.
    assign w_swap = w_cross[CROSS_W-1];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pass_d  = pass_q;
        j_d     = j_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        perm_d  = perm_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d[0]  = X;
                    y_d[0]  = Y;
                    r_d[0]  = R;
                    count_d = 3'd1;
                    // Previous object left perm scrambled; restart from identity.
                    for (int i = 0; i < NPTS; i++) begin
                        perm_d[i] = 3'(i);
                    end
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    x_d[count_q] = X;
                    y_d[count_q] = Y;
                    r_d[count_q] = R;
                    if (count_q == LAST_IDX) begin
                        count_d = 3'd0;
                        pass_d  = 3'd0;
                        j_d     = 3'd1;
                        state_d = S_SORT;
                    end else begin
                        count_d = count_q + 3'd1;
                    end
                end
            end
            S_SORT: begin
                if (w_swap) begin
                    perm_d[j_q]  = perm_q[w_j1];
                    perm_d[w_j1] = perm_q[j_q];
                end
                // Each pass shrinks by one: pass p ends at j = NPTS-2-p.
                if (j_q == (LAST_J - pass_q)) begin
                    if (pass_q == LAST_PASS) begin
                        k_d     = 3'd0;
                        state_d = S_EMIT;
                    end else begin
                        pass_d = pass_q + 3'd1;
                        j_d    = 3'd1;
                    end
                end else begin
                    j_d = w_j1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (k_q == LAST_IDX) begin
                        k_d     = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 3'd0;
            pass_q  <= 3'd0;
            j_q     <= 3'd0;
            k_q     <= 3'd0;
            for (int i = 0; i < NPTS; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                r_q[i]    <= '0;
                perm_q[i] <= 3'(i);
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
            j_q     <= j_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            perm_q  <= perm_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and muxed from registered buffers only.
    // ------------------------------------------------------------------
    logic       w_emit;
    logic [2:0] w_sel;

    assign w_emit    = (state_q == S_EMIT);
    assign w_sel     = perm_q[k_q];
    assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign out_valid = w_emit;
    assign busy      = (state_q == S_SORT) || w_emit;
    assign out_x     = w_emit ? x_q[w_sel] : '0;
    assign out_y     = w_emit ? y_q[w_sel] : '0;
    assign out_r     = w_emit ? r_q[w_sel] : '0;
    assign out_idx   = w_emit ? w_sel : 3'd0;
    assign out_last  = w_emit && (k_q == LAST_IDX);

endmodule
`default_nettype wire
